// File: rtl/apb_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_mc_pkg
// Description : Shared types and helpers for the multi-slave APB4 master.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_mc_pkg;

    // Transfer phase of the master
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Bits needed to index n items; never less than one bit
    function automatic int f_sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_decode.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_decode
// Description : Address-to-slave decode (index, decode error) for incoming
//               requests, one-hot select and return-path mux for the slave
//               latched by the current transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_decode
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_SHIFT  = 12
) (
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [f_sel_w(NUM_SLAVES)-1:0] i_sel_idx,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLAVES-1:0]        i_pready,
    input  logic [NUM_SLAVES-1:0]        i_pslverr,
    output logic [f_sel_w(NUM_SLAVES)-1:0] o_idx,
    output logic                         o_dec_err,
    output logic [NUM_SLAVES-1:0]        o_psel,
    output logic [DATA_W-1:0]            o_prdata,
    output logic                         o_pready,
    output logic                         o_pslverr
);

    localparam int                c_sel_w   = f_sel_w(NUM_SLAVES);
    localparam logic [ADDR_W-1:0] c_num_slv = ADDR_W'(NUM_SLAVES);

    logic [ADDR_W-1:0] w_full_idx;

    // Full-width index so out-of-range addresses are detected, not aliased
    assign w_full_idx = i_addr >> SLV_SHIFT;
    assign o_dec_err  = (w_full_idx >= c_num_slv);
    assign o_idx      = w_full_idx[c_sel_w-1:0];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_psel
        assign o_psel[g] = (i_sel_idx == c_sel_w'(g));
    end

    // Return path: only the addressed slave is observed
    always_comb begin
        o_prdata  = '0;
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_sel_idx == c_sel_w'(i)) begin
                o_prdata  = i_prdata[i*DATA_W +: DATA_W];
                o_pready  = i_pready[i];
                o_pslverr = i_pslverr[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_mc
// Description : Multi-slave APB4 master. Single valid/ready request port,
//               address-decoded slave select, wait states, byte strobes,
//               error reporting and an ACCESS-phase wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_mc
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLV_SHIFT   = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_strb,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    output logic [DATA_W/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int                 c_strb_w  = DATA_W / 8;
    localparam int                 c_sel_w   = f_sel_w(NUM_SLAVES);
    localparam int                 c_cnt_w   = f_sel_w(TIMEOUT_CYC + 1);
    localparam bit                 c_to_en   = (TIMEOUT_CYC != 0);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_write;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_strb_w-1:0]  r_strb;
    logic [c_sel_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic                 r_dec_pend;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_rsp_timeout;

    logic [c_sel_w-1:0]    w_req_idx;
    logic                  w_dec_err;
    logic [NUM_SLAVES-1:0] w_psel_1h;
    logic [DATA_W-1:0]     w_prdata;
    logic                  w_pready;
    logic                  w_pslverr;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_abort;
    logic                  w_idle_dec;

    apb_slave_decode #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_SHIFT  (SLV_SHIFT)
    ) u_decode (
        .i_addr    (req_addr),
        .i_sel_idx (r_idx),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr),
        .o_idx     (w_req_idx),
        .o_dec_err (w_dec_err),
        .o_psel    (w_psel_1h),
        .o_prdata  (w_prdata),
        .o_pready  (w_pready),
        .o_pslverr (w_pslverr)
    );

    // Phase sequencing; a decode error accepted at the end of a transfer is
    // parked for one IDLE cycle (ready low) so its response does not collide
    // with the completing transfer's response.
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !r_dec_pend;
                if (req_valid && !r_dec_pend && !w_dec_err) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_pready) begin
                    w_complete  = 1'b1;
                    w_req_ready = 1'b1;
                    w_next      = (req_valid && !w_dec_err) ? ST_SETUP : ST_IDLE;
                end else if (c_to_en && (r_wait_cnt == c_to_last)) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept   = req_valid && w_req_ready;
    assign w_idle_dec = (r_state == ST_IDLE) && w_accept && w_dec_err;

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch; bus lines only move for requests that reach the bus
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_idx   <= '0;
        end else if (w_accept && !w_dec_err) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_strb  <= req_write ? req_strb : '0;
            r_idx   <= w_req_idx;
        end
    end

    // Wait-state counter: cleared entering ACCESS, counts pready-low cycles
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !w_pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Deferred decode error from a back-to-back accept
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_dec_pend <= 1'b0;
        end else begin
            r_dec_pend <= (r_state == ST_ACCESS) && w_accept && w_dec_err;
        end
    end

    // Registered one-cycle response
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= w_complete || w_abort || r_dec_pend || w_idle_dec;
            r_rsp_err     <= (w_complete && w_pslverr) || w_abort || r_dec_pend || w_idle_dec;
            r_rsp_timeout <= w_abort;
            r_rsp_rdata   <= (w_complete && !r_write && !w_pslverr) ? w_prdata : '0;
        end
    end

    assign req_ready   = w_req_ready;
    assign psel        = (r_state == ST_IDLE) ? '0 : w_psel_1h;
    assign penable     = (r_state == ST_ACCESS);
    assign pwrite      = r_write;
    assign paddr       = r_addr;
    assign pwdata      = r_wdata;
    assign pstrb       = r_strb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_mc
// Description : Scoreboard bench for apb_master_mc with behavioural APB
//               slaves and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_mc;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int NSLV    = 4;
    localparam int TIMEOUT = 16;

    logic                   clk;
    logic                   presetn;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic [3:0]             req_strb;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   rsp_timeout;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [3:0]             pstrb;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;

    apb_master_mc #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NSLV),
        .SLV_SHIFT(12), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .pclk(clk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          cyc;
        bit          lat_chk;
    } exp_t;

    exp_t        exp_q[$];
    int          wait_q[$];
    logic [31:0] mdl_mem[int];
    logic [31:0] slv_mem[int];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          s_wait = 0;
    int          s_idx  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Contents of a never-written word, shared rule of the peripherals
    function automatic logic [31:0] f_dflt(input int key);
        return {key[15:0] ^ 16'hA5A5, key[15:0]};
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Behavioural APB slaves: wait count per transfer taken from wait_q,
    // pslverr when addr[7:4]==F, junk on every unselected return path.
    always @(negedge clk) begin
        for (int s = 0; s < NSLV; s++) begin
            pready[s]              = 1'($urandom_range(0, 1));
            pslverr[s]             = 1'($urandom_range(0, 1));
            prdata[s*DATA_W +: 32] = $urandom;
        end
        if (!presetn) begin
            s_wait = 0;
        end else if (psel != '0) begin
            for (int s = 0; s < NSLV; s++) if (psel[s]) s_idx = s;
            if (!penable) begin
                check("psel_decode", 64'(psel), 64'(4'b0001 << paddr[15:12]));
                if (wait_q.size() == 0) begin
                    check("unexpected_setup", 64'(1), 64'(0));
                    s_wait = 0;
                end else begin
                    s_wait = wait_q.pop_front();
                end
            end else if (s_wait == 0) begin
                int key;
                logic e;
                key = int'(paddr[15:2]);
                e   = (paddr[7:4] == 4'hF);
                pready[s_idx]  = 1'b1;
                pslverr[s_idx] = e;
                if (!pwrite) begin
                    check("pstrb_read", 64'(pstrb), 64'(0));
                    prdata[s_idx*DATA_W +: 32] = slv_mem.exists(key) ? slv_mem[key] : f_dflt(key);
                end else if (!e) begin
                    slv_mem[key] = f_merge(slv_mem.exists(key) ? slv_mem[key] : f_dflt(key),
                                           pwdata, pstrb);
                end
                s_wait = -1;
            end else begin
                pready[s_idx] = 1'b0;
                s_wait--;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT presents one
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (presetn && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                if (e.lat_chk) check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Present one request, wait for acceptance, record the expected outcome
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int w);
        exp_t e;
        int   budget;
        int   key;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = st;
        #2;
        budget = 0;
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            #2;
            budget++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(0), 64'(1));
            req_valid = 1'b0;
            return;
        end
        key       = int'(addr[15:2]);
        e.rdata   = '0;
        e.err     = 1'b0;
        e.to      = 1'b0;
        e.lat_chk = 1'b1;
        if (int'(addr[15:12]) >= NSLV) begin
            e.err     = 1'b1;
            e.cyc     = cyc + 1;
            e.lat_chk = (exp_q.size() == 0);
        end else begin
            wait_q.push_back(w);
            if (w >= TIMEOUT) begin
                e.err = 1'b1;
                e.to  = 1'b1;
                e.cyc = cyc + 3 + (TIMEOUT - 1);
            end else begin
                e.err = (addr[7:4] == 4'hF);
                e.cyc = cyc + 3 + w;
                if (!e.err) begin
                    if (wr)
                        mdl_mem[key] = f_merge(mdl_mem.exists(key) ? mdl_mem[key] : f_dflt(key), wd, st);
                    else
                        e.rdata = mdl_mem.exists(key) ? mdl_mem[key] : f_dflt(key);
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          w;
        int          budget;
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_pstrb", 64'(pstrb), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        presetn = 1'b1;
        #2;
        check("ready_after_rst", 64'(req_ready), 64'(1));

        // Zero-wait write to slave 1 with cycle-exact phase checks
        issue(1'b1, 16'h1004, 32'hDEADBEEF, 4'hF, 0);
        idle();
        #2;
        check("setup_psel", 64'({psel, penable}), 64'({4'b0010, 1'b0}));
        @(negedge clk);
        #2;
        check("access_psel", 64'({psel, penable, pwrite}), 64'({4'b0010, 1'b1, 1'b1}));
        check("access_pwdata", 64'(pwdata), 64'(32'hDEADBEEF));

        // Read with three wait states after a preload
        issue(1'b1, 16'h3010, 32'h12345678, 4'hF, 0);
        idle();
        repeat (3) @(negedge clk);
        issue(1'b0, 16'h3010, 32'h0, 4'hF, 3);
        idle();
        repeat (6) @(negedge clk);

        // Back-to-back write then read, partial strobe
        issue(1'b1, 16'h2008, 32'hCAFEF00D, 4'h5, 1);
        issue(1'b0, 16'h2008, 32'h0, 4'h0, 0);
        issue(1'b0, 16'h1004, 32'h0, 4'h0, 0);
        idle();
        repeat (5) @(negedge clk);

        // Decode error, pslverr, and the timeout boundary
        issue(1'b0, 16'h5000, 32'h0, 4'h0, 0);
        issue(1'b1, 16'h20F4, 32'h11111111, 4'hF, 0);
        issue(1'b0, 16'h20F4, 32'h0, 4'h0, 2);
        issue(1'b0, 16'h1008, 32'h0, 4'h0, TIMEOUT - 1);
        issue(1'b0, 16'h1008, 32'h0, 4'h0, TIMEOUT);
        issue(1'b0, 16'hF000, 32'h0, 4'h0, 0);
        idle();
        repeat (25) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            a = {4'($urandom_range(0, 3)), 4'h0,
                 ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[15:12] = 4'($urandom_range(4, 15));
            case ($urandom_range(0, 19))
                0:       w = $urandom_range(TIMEOUT, TIMEOUT + 3);
                1:       w = $urandom_range(5, TIMEOUT - 1);
                default: w = $urandom_range(0, 4);
            endcase
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idle();
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain_rsp", 64'(exp_q.size()), 64'(0));
        check("drain_waits", 64'(wait_q.size()), 64'(0));

        // Asynchronous reset in the middle of a stalled ACCESS
        issue(1'b0, 16'h1000, 32'h0, 4'h0, 1000);
        idle();
        repeat (5) @(negedge clk);
        check("pre_rst_access", 64'({psel, penable}), 64'({4'b0010, 1'b1}));
        #3;
        presetn = 1'b0;
        #1;
        check("async_rst_bus", 64'({psel, penable}), 64'(0));
        check("async_rst_rsp", 64'(rsp_valid), 64'(0));
        exp_q.delete();
        wait_q.delete();
        repeat (2) @(negedge clk);
        presetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
        end
        issue(1'b1, 16'h3000, 32'hA5A55A5A, 4'hF, 0);
        issue(1'b0, 16'h3000, 32'h0, 4'h0, 1);
        idle();
        repeat (10) @(negedge clk);
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
